topk_ordered_list: RTL and testbench

TOPK_ORDERED_LIST -- requirements
Module: topk_ordered_list

---
 rtl/topk_ordered_list.sv | 135 +++++++++++++
 tb/tb_topk_ordered_list.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/topk_ordered_list.sv
// topk_ordered_list: best-first ordered top-K list with insert channel and in-order drain.
// Entries stay contiguous from index 0; inserts shift worse entries down, drain pops entry 0.
module topk_ordered_list #(
    parameter int COMP_W    = 32,
    parameter int BAG_W     = 32,
    parameter int LIST_SIZE = 8,
    parameter bit DESCEND   = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [COMP_W-1:0]                 in_comp,
    input  logic [BAG_W-1:0]                  in_bag,
    input  logic                              drain_start,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [COMP_W-1:0]                 rd_comp,
    output logic [BAG_W-1:0]                  rd_bag,
    output logic                              rd_last,
    output logic [$clog2(LIST_SIZE+1)-1:0]    count,
    output logic                              full,
    output logic [COMP_W*LIST_SIZE-1:0]       comp_out,
    output logic [BAG_W*LIST_SIZE-1:0]        bag_out,
    output logic [LIST_SIZE-1:0]              entry_valid
);
    localparam int CW = $clog2(LIST_SIZE+1);

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t              r_state, w_state_n;
    logic [COMP_W-1:0]   r_comp [LIST_SIZE];
    logic [COMP_W-1:0]   w_comp_n [LIST_SIZE];
    logic [COMP_W-1:0]   w_comp_dn [LIST_SIZE];
    logic [COMP_W-1:0]   w_comp_up [LIST_SIZE];
    logic [BAG_W-1:0]    r_bag [LIST_SIZE];
    logic [BAG_W-1:0]    w_bag_n [LIST_SIZE];
    logic [BAG_W-1:0]    w_bag_dn [LIST_SIZE];
    logic [BAG_W-1:0]    w_bag_up [LIST_SIZE];
    logic [LIST_SIZE-1:0] r_vld, w_vld_n, w_vld_dn, w_ge, w_ge_prev;
    logic [CW-1:0]       r_count, w_count_n;
    logic                w_ins, w_pop;

    // w_ge is a prefix mask: ones mark valid entries at least as good as in_comp
    for (genvar g = 0; g < LIST_SIZE; g++) begin : g_ent
        assign w_ge[g] = r_vld[g] && (DESCEND ? (r_comp[g] >= in_comp) : (r_comp[g] <= in_comp));
        assign comp_out[g*COMP_W +: COMP_W] = r_comp[g];
        assign bag_out[g*BAG_W +: BAG_W]    = r_bag[g];
        if (g == 0) begin : g_first
            assign w_comp_dn[g] = '0;
            assign w_bag_dn[g]  = '0;
        end else begin : g_dn
            assign w_comp_dn[g] = r_comp[g-1];
            assign w_bag_dn[g]  = r_bag[g-1];
        end
        if (g == LIST_SIZE-1) begin : g_last
            assign w_comp_up[g] = '0;
            assign w_bag_up[g]  = '0;
        end else begin : g_up
            assign w_comp_up[g] = r_comp[g+1];
            assign w_bag_up[g]  = r_bag[g+1];
        end
    end

    assign w_ge_prev   = {w_ge[LIST_SIZE-2:0], 1'b1};
    assign w_vld_dn    = {r_vld[LIST_SIZE-2:0], 1'b0};
    assign in_ready    = (r_state == S_IDLE);
    assign w_ins       = in_ready && in_valid && !w_ge[LIST_SIZE-1];
    assign rd_valid    = (r_state == S_DRAIN);
    assign w_pop       = rd_valid && rd_ready;
    assign rd_comp     = rd_valid ? r_comp[0] : '0;
    assign rd_bag      = rd_valid ? r_bag[0] : '0;
    assign rd_last     = rd_valid && (r_count == CW'(1));
    assign count       = r_count;
    assign full        = (r_count == CW'(LIST_SIZE));
    assign entry_valid = r_vld;

    always_comb begin
        w_state_n = r_state;
        if (clear)
            w_state_n = S_IDLE;
        else if (r_state == S_IDLE)
            w_state_n = (drain_start && (r_count != '0 || w_ins)) ? S_DRAIN : S_IDLE;
        else if (w_pop && rd_last)
            w_state_n = S_IDLE;
    end

    always_comb begin
        w_comp_n  = r_comp;
        w_bag_n   = r_bag;
        w_vld_n   = r_vld;
        w_count_n = r_count;
        if (clear) begin
            for (int i = 0; i < LIST_SIZE; i++) begin
                w_comp_n[i] = '0;
                w_bag_n[i]  = '0;
            end
            w_vld_n   = '0;
            w_count_n = '0;
        end else if (w_ins) begin
            for (int i = 0; i < LIST_SIZE; i++) begin
                if (!w_ge[i]) begin
                    w_comp_n[i] = w_ge_prev[i] ? in_comp : w_comp_dn[i];
                    w_bag_n[i]  = w_ge_prev[i] ? in_bag : w_bag_dn[i];
                    w_vld_n[i]  = w_ge_prev[i] | w_vld_dn[i];
                end
            end
            w_count_n = full ? r_count : r_count + CW'(1);
        end else if (w_pop) begin
            w_comp_n  = w_comp_up;
            w_bag_n   = w_bag_up;
            w_vld_n   = {1'b0, r_vld[LIST_SIZE-1:1]};
            w_count_n = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < LIST_SIZE; i++) begin
                r_comp[i] <= '0;
                r_bag[i]  <= '0;
            end
        end else begin
            r_state <= w_state_n;
            r_count <= w_count_n;
            r_vld   <= w_vld_n;
            r_comp  <= w_comp_n;
            r_bag   <= w_bag_n;
        end
    end
endmodule

// File: tb/tb_topk_ordered_list.sv
// tb_topk_ordered_list: ascending and descending instances share stimulus; queue models predict
// list contents, and a readout scoreboard checks every rd handshake.
module tb_topk_ordered_list;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst, clear, in_valid, drain_start, rd_ready;
    logic [7:0] in_comp, in_bag;
    logic [1:0] in_ready, rd_valid, rd_last, full;
    logic [7:0] rd_comp [2];
    logic [7:0] rd_bag [2];
    logic [2:0] count [2];
    logic [31:0] comp_out [2];
    logic [31:0] bag_out [2];
    logic [3:0] entry_valid [2];

    logic [15:0] mq [2][$];
    logic [16:0] eq [2][$];
    bit md [2];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    topk_ordered_list #(.COMP_W(8), .BAG_W(8), .LIST_SIZE(L), .DESCEND(1'b0)) u_asc (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_comp(in_comp), .in_bag(in_bag), .drain_start(drain_start), .rd_valid(rd_valid[0]),
        .rd_ready(rd_ready), .rd_comp(rd_comp[0]), .rd_bag(rd_bag[0]), .rd_last(rd_last[0]),
        .count(count[0]), .full(full[0]), .comp_out(comp_out[0]), .bag_out(bag_out[0]),
        .entry_valid(entry_valid[0]));

    topk_ordered_list #(.COMP_W(8), .BAG_W(8), .LIST_SIZE(L), .DESCEND(1'b1)) u_desc (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_comp(in_comp), .in_bag(in_bag), .drain_start(drain_start), .rd_valid(rd_valid[1]),
        .rd_ready(rd_ready), .rd_comp(rd_comp[1]), .rd_bag(rd_bag[1]), .rd_last(rd_last[1]),
        .count(count[1]), .full(full[1]), .comp_out(comp_out[1]), .bag_out(bag_out[1]),
        .entry_valid(entry_valid[1]));

    task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    function automatic bit better_eq(input bit desc, input logic [7:0] e, input logic [7:0] c);
        return desc ? (e >= c) : (e <= c);
    endfunction

    task automatic model_step(input int k);
        int p;
        if (rst || clear) begin
            mq[k].delete();
            eq[k].delete();
            md[k] = 1'b0;
            return;
        end
        if (!md[k]) begin
            if (in_valid) begin
                p = 0;
                for (int i = 0; i < mq[k].size(); i++)
                    if (better_eq(k == 1, mq[k][i][15:8], in_comp)) p++;
                if (p < L) begin
                    mq[k].insert(p, {in_comp, in_bag});
                    if (mq[k].size() > L) void'(mq[k].pop_back());
                end
            end
            if (drain_start && mq[k].size() > 0) begin
                md[k] = 1'b1;
                for (int i = 0; i < mq[k].size(); i++)
                    eq[k].push_back({i == mq[k].size() - 1, mq[k][i]});
            end
        end else if (rd_ready) begin
            void'(mq[k].pop_front());
            if (mq[k].size() == 0) md[k] = 1'b0;
        end
    endtask

    task automatic compare_state(input int k);
        logic [31:0] ec, eb;
        logic [3:0] ev;
        int n;
        ec = '0; eb = '0; ev = '0;
        n = mq[k].size();
        for (int i = 0; i < n; i++) begin
            ec[i*8 +: 8] = mq[k][i][15:8];
            eb[i*8 +: 8] = mq[k][i][7:0];
            ev[i] = 1'b1;
        end
        check("count", k, count[k], n);
        check("full", k, full[k], n == L);
        check("entry_valid", k, entry_valid[k], ev);
        check("comp_out", k, comp_out[k], ec);
        check("bag_out", k, bag_out[k], eb);
        check("in_ready", k, in_ready[k], !md[k]);
        check("rd_valid", k, rd_valid[k], md[k]);
        check("rd_comp", k, rd_comp[k], md[k] ? ec[7:0] : 8'h0);
        check("rd_bag", k, rd_bag[k], md[k] ? eb[7:0] : 8'h0);
        check("rd_last", k, rd_last[k], md[k] && n == 1);
    endtask

    task automatic step(input bit iv, input logic [7:0] ic, input logic [7:0] ib,
                        input bit ds, input bit rr, input bit clr, input bit rs);
        in_valid = iv; in_comp = ic; in_bag = ib; drain_start = ds;
        rd_ready = rr; clear = clr; rst = rs;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_state(0);
        compare_state(1);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd_valid[k] === 1'b1 && rd_ready === 1'b1) begin
                if (eq[k].size() == 0) begin
                    check("rd_unexpected", k, rd_valid[k], 0);
                end else begin
                    logic [16:0] e;
                    e = eq[k].pop_front();
                    check("sb_comp", k, rd_comp[k], e[15:8]);
                    check("sb_bag", k, rd_bag[k], e[7:0]);
                    check("sb_last", k, rd_last[k], e[16]);
                end
            end
        end
    end

    initial begin
        bit ds, rr, clr, rs;
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        // ascending fill and overflow behaviour
        step(1, 7, 1, 0, 0, 0, 0);
        step(1, 3, 2, 0, 0, 0, 0);
        step(1, 9, 3, 0, 0, 0, 0);
        step(1, 5, 4, 0, 0, 0, 0);
        check("fill_comp", 0, comp_out[0], 32'h09070503);
        check("fill_bag", 0, bag_out[0], 32'h03010402);
        check("fill_count", 0, count[0], 4);
        check("fill_full", 0, full[0], 1);
        step(1, 4, 5, 0, 0, 0, 0);
        check("drop_worst", 0, comp_out[0], 32'h07050403);
        step(1, 10, 6, 0, 0, 0, 0);
        check("discard", 0, comp_out[0], 32'h07050403);
        check("discard_count", 0, count[0], 4);
        // drain with backpressure
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("held_comp", 0, rd_comp[0], 4);
        step(1, 1, 9, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        check("drained_count", 0, count[0], 0);
        check("drained_ready", 0, in_ready[0], 1);
        // ties keep arrival order
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 5, 8'hA, 0, 0, 0, 0);
        step(1, 5, 8'hB, 0, 0, 0, 0);
        check("tie_order", 0, bag_out[0][15:0], 16'h0B0A);
        // descending order and empty drain request
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 2, 1, 0, 0, 0, 0);
        step(1, 8, 2, 0, 0, 0, 0);
        step(1, 6, 3, 0, 0, 0, 0);
        check("desc_order", 1, comp_out[1], 32'h00020608);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("empty_drain", 1, rd_valid[1], 0);
        // insert on the drain cycle from empty, then clear mid-drain
        step(1, 3, 1, 1, 0, 0, 0);
        check("ins_drain", 0, rd_comp[0], 3);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 6, 1, 0, 0, 0, 0);
        step(1, 2, 2, 0, 0, 0, 0);
        step(1, 4, 3, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("clear_count", 0, count[0], 0);
        check("clear_valid", 0, rd_valid[0], 0);
        check("clear_ready", 0, in_ready[0], 1);
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 2, 2, 0, 0, 0, 1);
        check("rst_count", 0, count[0], 0);
        // randomized traffic
        for (int t = 0; t < 800; t++) begin
            ds  = ($urandom % 6) == 0;
            rr  = ($urandom % 3) != 0;
            clr = ($urandom % 60) == 0;
            rs  = ($urandom % 150) == 0;
            if (clr || rs) rr = 1'b0;
            step($urandom % 2, 8'($urandom % 16), 8'($urandom), ds, rr, clr, rs);
        end
        for (int t = 0; t < 2 * L + 2 && (md[0] || md[1]); t++)
            step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("sb_empty", 0, eq[0].size(), 0);
        check("sb_empty", 1, eq[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end
endmodule
